collision_event_sequencer: RTL and testbench

//  Per-frame scheduler for collision events in the Space-Invaders VGA pipeline.

---
 rtl/collision_pkg.sv | 22 ++
 rtl/ev_priority_enc.sv | 26 ++
 rtl/collision_event_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_collision_event_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// collision_pkg
//   Shared types and constants for the collision event sequencer.
//   ev_id_t     : event class indices, in fixed priority order (0 = highest)
//   seq_state_t : sequencer FSM states
package collision_pkg;

  localparam int NUM_EV_DEFAULT = 5;

  typedef enum logic [2:0] {
    EV_PROJ_BORDER   = 3'd0,
    EV_PROJ_SHIELD   = 3'd1,
    EV_BANANA_BORDER = 3'd2,
    EV_BANANA_SHIP   = 3'd3,
    EV_BANANA_SHIELD = 3'd4
  } ev_id_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ev_priority_enc.sv
// ev_priority_enc
//   Combinational lowest-index priority encoder.
//   Ports:
//     vec     in  N     request vector
//     idx     out ID_W  index of the lowest set bit (0 when none set)
//     any_set out 1     at least one bit of vec is set
module ev_priority_enc #(
  parameter int N    = 5,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    vec,
  output logic [ID_W-1:0] idx,
  output logic            any_set
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

  assign any_set = |vec;

endmodule

// File: rtl/collision_event_sequencer.sv
// collision_event_sequencer
//   Captures per-class collision strobes and first-hit pixel during a frame;
//   at startOfFrame moves the captured set to a drain bank and presents the
//   events one per accept, lowest class index first, on a valid/ready port.
//   Optional build macro: HIT_COUNT_EN (per-class saturating hit-pixel counters
//   reported on ev_count; without it ev_count is tied to 0).
//   Ports:
//     clk, resetN (async, active-low)
//     startOfFrame         1-cycle frame start pulse
//     pixelX, pixelY       current pixel
//     ev_hit   [NUM_EV]    per-class collision strobe
//     ev_valid/ev_ready    event handshake
//     ev_id, ev_x, ev_y    presented class and its first-hit coordinates
//     ev_count             hit pixels of the presented class
//     overrun              pulse: undelivered events dropped at startOfFrame
//
//   state   | meaning
//   S_IDLE  | drain bank empty, ev_valid low
//   S_DRAIN | drain bank has pending events, one presented on ev_*
module collision_event_sequencer
  import collision_pkg::*;
#(
  parameter int NUM_EV = NUM_EV_DEFAULT,
  parameter int X_W    = 11,
  parameter int Y_W    = 11,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic [X_W-1:0]            pixelX,
  input  logic [Y_W-1:0]            pixelY,
  input  logic [NUM_EV-1:0]         ev_hit,
  output logic                      ev_valid,
  output logic [$clog2(NUM_EV)-1:0] ev_id,
  output logic [X_W-1:0]            ev_x,
  output logic [Y_W-1:0]            ev_y,
  output logic [CNT_W-1:0]          ev_count,
  input  logic                      ev_ready,
  output logic                      overrun
);

  localparam int ID_W = $clog2(NUM_EV);
  localparam logic [0:0] ST_IDLE  = S_IDLE;
  localparam logic [0:0] ST_DRAIN = S_DRAIN;

  logic [0:0]        state_q;
  logic [NUM_EV-1:0] cap_pend, drain_pend;
  logic [X_W-1:0]    cap_x [NUM_EV];
  logic [Y_W-1:0]    cap_y [NUM_EV];
  logic [X_W-1:0]    drain_x [NUM_EV];
  logic [Y_W-1:0]    drain_y [NUM_EV];

  logic              accept;
  logic [NUM_EV-1:0] acc_mask, leftover, pend_nxt;
  logic [ID_W-1:0]   idx_nxt;
  logic              any_nxt;
  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;

  assign ev_valid = (state_q == ST_DRAIN);
  assign accept   = ev_valid && ev_ready;

  always_comb begin
    acc_mask = '0;
    for (int i = 0; i < NUM_EV; i++) acc_mask[i] = accept && (ev_id == ID_W'(i));
  end

  assign leftover = drain_pend & ~acc_mask;
  // At frame start the freshly captured bank replaces whatever is left.
  assign pend_nxt = startOfFrame ? cap_pend : leftover;

  ev_priority_enc #(.N(NUM_EV), .ID_W(ID_W)) u_enc (
    .vec     (pend_nxt),
    .idx     (idx_nxt),
    .any_set (any_nxt)
  );

  // Outputs are registered from the next-cycle bank, so the data source
  // follows the same startOfFrame mux as pend_nxt.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    if (any_nxt) begin
      sel_x = startOfFrame ? cap_x[idx_nxt] : drain_x[idx_nxt];
      sel_y = startOfFrame ? cap_y[idx_nxt] : drain_y[idx_nxt];
    end
  end

  // Capture bank: a hit on the startOfFrame cycle opens the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cap_pend <= '0;
      for (int i = 0; i < NUM_EV; i++) begin
        cap_x[i] <= '0;
        cap_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EV; i++) begin
        if (startOfFrame) begin
          cap_pend[i] <= ev_hit[i];
          if (ev_hit[i]) begin
            cap_x[i] <= pixelX;
            cap_y[i] <= pixelY;
          end
        end else if (ev_hit[i] && !cap_pend[i]) begin
          cap_pend[i] <= 1'b1;
          cap_x[i]    <= pixelX;
          cap_y[i]    <= pixelY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drain_pend <= '0;
      for (int i = 0; i < NUM_EV; i++) begin
        drain_x[i] <= '0;
        drain_y[i] <= '0;
      end
    end else begin
      drain_pend <= pend_nxt;
      if (startOfFrame) begin
        drain_x <= cap_x;
        drain_y <= cap_y;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      ev_id   <= '0;
      ev_x    <= '0;
      ev_y    <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= any_nxt ? ST_DRAIN : ST_IDLE;
      ev_id   <= any_nxt ? idx_nxt : '0;
      ev_x    <= sel_x;
      ev_y    <= sel_y;
      overrun <= startOfFrame && (|leftover);
    end
  end

`ifdef HIT_COUNT_EN
  logic [CNT_W-1:0] cap_cnt   [NUM_EV];
  logic [CNT_W-1:0] drain_cnt [NUM_EV];
  logic [CNT_W-1:0] sel_cnt;

  always_comb begin
    sel_cnt = '0;
    if (any_nxt) sel_cnt = startOfFrame ? cap_cnt[idx_nxt] : drain_cnt[idx_nxt];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_EV; i++) begin
        cap_cnt[i]   <= '0;
        drain_cnt[i] <= '0;
      end
      ev_count <= '0;
    end else begin
      for (int i = 0; i < NUM_EV; i++) begin
        if (startOfFrame) begin
          cap_cnt[i] <= ev_hit[i] ? CNT_W'(1) : '0;
        end else if (ev_hit[i] && (cap_cnt[i] != '1)) begin
          cap_cnt[i] <= cap_cnt[i] + 1'b1;
        end
      end
      if (startOfFrame) drain_cnt <= cap_cnt;
      ev_count <= sel_cnt;
    end
  end
`else
  assign ev_count = '0;
`endif

endmodule

// File: tb/tb_collision_event_sequencer.sv
module tb_collision_event_sequencer;

  localparam int NEV     = 5;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic [4:0]  ev_hit;
  logic        ev_valid;
  logic [2:0]  ev_id;
  logic [10:0] ev_x, ev_y;
  logic [7:0]  ev_count;
  logic        ev_ready;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  collision_event_sequencer dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .ev_hit       (ev_hit),
    .ev_valid     (ev_valid),
    .ev_id        (ev_id),
    .ev_x         (ev_x),
    .ev_y         (ev_y),
    .ev_count     (ev_count),
    .ev_ready     (ev_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: per-frame capture as plain arrays, drained frame as a
  // queue of events in delivery order.
  typedef struct {
    int id;
    int x;
    int y;
    int cnt;
  } ev_t;

  ev_t q[$];
  bit  m_hit [NEV];
  int  m_x   [NEV];
  int  m_y   [NEV];
  int  m_cnt [NEV];
  bit  exp_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < NEV; i++) begin
      m_hit[i] = 0;
      m_cnt[i] = 0;
    end
    exp_ov = 0;
  endtask

  task automatic model_hit(input logic [4:0] hit, input int x, input int y);
    for (int i = 0; i < NEV; i++) begin
      if (hit[i]) begin
        if (!m_hit[i]) begin
          m_hit[i] = 1;
          m_x[i]   = x;
          m_y[i]   = y;
        end
        if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
      end
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input logic [4:0] hit, input int x, input int y,
                      input logic sof, input logic rdy);
    bit acc;
    ev_t e;
    ev_hit       = hit;
    pixelX       = 11'(x);
    pixelY       = 11'(y);
    startOfFrame = sof;
    ev_ready     = rdy;
    @(negedge clk);
    if (q.size() > 0) begin
      chk("ev_valid", 32'(ev_valid), 1);
      chk("ev_id", 32'(ev_id), q[0].id);
      chk("ev_x", 32'(ev_x), q[0].x);
      chk("ev_y", 32'(ev_y), q[0].y);
      chk("ev_count", 32'(ev_count), q[0].cnt);
    end else begin
      chk("ev_valid_idle", 32'(ev_valid), 0);
    end
    chk("overrun", 32'(overrun), 32'(exp_ov));
    acc = (q.size() > 0) && rdy;
    if (acc) void'(q.pop_front());
    exp_ov = sof && (q.size() > 0);
    if (sof) begin
      q.delete();
      for (int i = 0; i < NEV; i++) begin
        if (m_hit[i]) begin
          e.id = i;
          e.x  = m_x[i];
          e.y  = m_y[i];
`ifdef HIT_COUNT_EN
          e.cnt = m_cnt[i];
`else
          e.cnt = 0;
`endif
          q.push_back(e);
        end
        m_hit[i] = 0;
        m_cnt[i] = 0;
      end
    end
    model_hit(hit, x, y);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(5'b0, 0, 0, 1'b0, rdy);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    ev_hit = '0; ev_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_id", 32'(ev_id), 0);
    chk("rst_x", 32'(ev_x), 0);
    chk("rst_y", 32'(ev_y), 0);
    chk("rst_count", 32'(ev_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // 1: single class, first hit wins
    step(5'b00010, 100, 200, 1'b0, 1'b1);
    step(5'b00010, 101, 200, 1'b0, 1'b1);
    step(5'b0, 0, 0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 2: classes 3 and 0 delivered in index order back to back
    step(5'b01000, 10, 20, 1'b0, 1'b1);
    step(5'b00001, 30, 40, 1'b0, 1'b1);
    step(5'b01001, 50, 60, 1'b0, 1'b1);
    step(5'b0, 0, 0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // 3: consumer stalls across a frame boundary -> overrun, old events lost
    step(5'b00110, 7, 8, 1'b0, 1'b0);
    step(5'b0, 0, 0, 1'b1, 1'b0);
    step(5'b10000, 300, 400, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(5'b0, 0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // 4: hit on the startOfFrame cycle belongs to the next frame
    step(5'b00100, 55, 66, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(5'b0, 0, 0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 5: reset during drain
    step(5'b00011, 12, 34, 1'b0, 1'b0);
    step(5'b0, 0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    resetN = 1'b0;
    #2;
    chk("rst_mid_valid", 32'(ev_valid), 0);
    chk("rst_mid_overrun", 32'(overrun), 0);
    model_clear();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    step(5'b01000, 77, 88, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(5'b0, 0, 0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 6: 300 hit cycles on class 4 -> saturated count (or 0 without counters)
    for (int c = 0; c < 300; c++) step(5'b10000, 500 + (c % 50), 9, 1'b0, 1'b1);
    step(5'b0, 0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // empty frame: nothing presented, no overrun
    idle(5, 1'b1);
    step(5'b0, 0, 0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(5, 25);
      for (int c = 0; c < len; c++) begin
        logic [4:0] h;
        h = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
        step(h, $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0,
             1'($urandom_range(0, 3) != 0));
      end
      step(($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'b0,
           $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b1,
           1'($urandom_range(0, 1)));
    end
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
